// File: rtl/inst_fetch_bridge.sv
// rtl/inst_fetch_bridge.sv - instruction fetch bridge between translation stage and SRAM-like bus
module inst_fetch_bridge #(
   parameter int MAX_OUT   = 2,
   parameter int BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_paddr,
   input  logic        in_uncached,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   output logic        inst_uncached,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst
);

   localparam int PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int BW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int OCW = $clog2(MAX_OUT + 1);
   localparam int BCW = $clog2(BUF_DEPTH + 1);

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;

   state_e state_q, state_d;

   // request held on the bus during the address phase
   logic [31:0] req_pc_q;
   logic [31:0] req_paddr_q;
   logic        req_unc_q;
   logic        req_kill_q;

   // pcs of address-accepted transactions awaiting data, oldest at rd pointer
   logic [31:0]        pf_pc_q [MAX_OUT];
   logic [MAX_OUT-1:0] pf_kill_q;
   logic [PW-1:0]      pf_wr_q, pf_rd_q;
   logic [OCW-1:0]     pf_cnt_q;

   // instructions ready for decode
   logic [31:0]    ob_pc_q   [BUF_DEPTH];
   logic [31:0]    ob_inst_q [BUF_DEPTH];
   logic [BW-1:0]  ob_wr_q, ob_rd_q;
   logic [BCW-1:0] ob_cnt_q;

   logic [15:0] used;
   logic        has_credit;
   logic        accept;
   logic        addr_hs;
   logic        data_hs;
   logic        ob_push;
   logic        ob_pop;
   logic        unused_paddr_lo;

   assign unused_paddr_lo = ^in_paddr[1:0];

   function automatic logic [PW-1:0] pf_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [BW-1:0] ob_inc(input logic [BW-1:0] p);
      return (p == BW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // a credit is one buffer slot not yet promised to a buffered, in-flight or pending fetch
   always_comb begin
      used       = 16'(ob_cnt_q) + 16'(pf_cnt_q) + ((state_q == REQ) ? 16'd1 : 16'd0);
      has_credit = (used < 16'(BUF_DEPTH));
   end

   // address-phase FSM: next state and handshake outputs
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      inst_req = 1'b0;
      accept   = 1'b0;
      addr_hs  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = has_credit && (pf_cnt_q < OCW'(MAX_OUT)) && !flush && !reset;
            accept   = in_valid && in_ready;
            if (accept) state_d = REQ;
         end
         REQ: begin
            inst_req = 1'b1;
            if (inst_addr_ok) begin
               addr_hs = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign inst_addr     = {req_paddr_q[31:2], 2'b00};
   assign inst_uncached = req_unc_q;

   // data_ok without anything outstanding is a bus protocol error and is ignored
   assign data_hs = inst_data_ok && (pf_cnt_q != '0);
   assign ob_push = data_hs && !pf_kill_q[pf_rd_q] && !flush;
   assign ob_pop  = out_valid && out_ready;

   // state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // capture the accepted request; a flush while it waits on the bus marks it dead
   always_ff @(posedge clk) begin
      if (reset) begin
         req_pc_q    <= '0;
         req_paddr_q <= '0;
         req_unc_q   <= 1'b0;
         req_kill_q  <= 1'b0;
      end else if (accept) begin
         req_pc_q    <= in_pc;
         req_paddr_q <= in_paddr;
         req_unc_q   <= in_uncached;
         req_kill_q  <= 1'b0;
      end else if ((state_q == REQ) && flush) begin
         req_kill_q  <= 1'b1;
      end
   end

   // pc FIFO: push on addr_ok, pop on data_ok; flush kills every entry including one pushed now
   always_ff @(posedge clk) begin
      if (reset) begin
         pf_kill_q <= '0;
         pf_wr_q   <= '0;
         pf_rd_q   <= '0;
         pf_cnt_q  <= '0;
      end else begin
         if (flush) pf_kill_q <= '1;
         if (addr_hs) begin
            pf_pc_q[pf_wr_q]   <= req_pc_q;
            pf_kill_q[pf_wr_q] <= req_kill_q || flush;
            pf_wr_q            <= pf_inc(pf_wr_q);
         end
         if (data_hs) pf_rd_q <= pf_inc(pf_rd_q);
         case ({addr_hs, data_hs})
            2'b10:   pf_cnt_q <= pf_cnt_q + 1'b1;
            2'b01:   pf_cnt_q <= pf_cnt_q - 1'b1;
            default: pf_cnt_q <= pf_cnt_q;
         endcase
      end
   end

   // output buffer: live responses in, decode pops out, flush empties it
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         ob_wr_q  <= '0;
         ob_rd_q  <= '0;
         ob_cnt_q <= '0;
      end else begin
         if (ob_push) begin
            ob_pc_q[ob_wr_q]   <= pf_pc_q[pf_rd_q];
            ob_inst_q[ob_wr_q] <= inst_rdata;
            ob_wr_q            <= ob_inc(ob_wr_q);
         end
         if (ob_pop) ob_rd_q <= ob_inc(ob_rd_q);
         case ({ob_push, ob_pop})
            2'b10:   ob_cnt_q <= ob_cnt_q + 1'b1;
            2'b01:   ob_cnt_q <= ob_cnt_q - 1'b1;
            default: ob_cnt_q <= ob_cnt_q;
         endcase
      end
   end

   assign out_valid = (ob_cnt_q != '0);
   assign out_pc    = out_valid ? ob_pc_q[ob_rd_q]   : '0;
   assign out_inst  = out_valid ? ob_inst_q[ob_rd_q] : '0;

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// tb/tb_inst_fetch_bridge.sv - randomized scoreboard bench for inst_fetch_bridge
module tb_inst_fetch_bridge;

   localparam int MAX_OUT   = 2;
   localparam int BUF_DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset, flush;
   logic [31:0] in_pc, in_paddr;
   logic        in_uncached, in_valid, in_ready;
   logic        inst_req, inst_uncached, inst_addr_ok, inst_data_ok;
   logic [31:0] inst_addr, inst_rdata;
   logic        out_valid, out_ready;
   logic [31:0] out_pc, out_inst;

   inst_fetch_bridge #(.MAX_OUT(MAX_OUT), .BUF_DEPTH(BUF_DEPTH)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_pc(in_pc), .in_paddr(in_paddr), .in_uncached(in_uncached),
      .in_valid(in_valid), .in_ready(in_ready),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_uncached(inst_uncached),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pa;
      logic        unc;
      int          ep;
      int          due;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } out_t;

   req_t        feed_q[$];   // requests waiting to be offered
   req_t        req_q[$];    // accepted, address phase not done
   req_t        bus_q[$];    // address accepted, data not returned
   out_t        exp_q[$];    // instructions decode should see, in order
   logic [31:0] pop_pc[$];
   logic [31:0] pop_inst[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int epoch = 0;
   int req_wait = 0;
   int addr_dly_cur = 0;
   int addr_dly_fix = 1;
   int data_dly_fix = 2;
   int rdy_mode = 1;
   int req_hi = 0;
   bit vld_rand = 0;
   bit spur_en = 0;
   bit flush_rand = 0;
   bit do_flush = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[31:2], 2'b00} ^ 32'h1E800000;
   endfunction

   task automatic feed(input logic [31:0] pc, input logic [31:0] pa, input logic unc);
      req_t r;
      r.pc = pc; r.pa = pa; r.unc = unc; r.ep = 0; r.due = 0;
      feed_q.push_back(r);
   endtask

   task automatic step();
      req_t e;
      out_t o;
      logic exp_rdy;
      @(negedge clk);
      flush    = do_flush || (flush_rand && ($urandom_range(0, 29) == 0));
      in_valid = (feed_q.size() != 0) && (!vld_rand || ($urandom_range(0, 3) != 0));
      if (feed_q.size() != 0) begin
         in_pc = feed_q[0].pc; in_paddr = feed_q[0].pa; in_uncached = feed_q[0].unc;
      end else begin
         in_pc = $urandom(); in_paddr = $urandom(); in_uncached = 1'b0;
      end
      case (rdy_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
      inst_data_ok = 1'b0;
      inst_rdata   = $urandom();
      if (bus_q.size() != 0 && bus_q[0].due <= cyc) begin
         inst_data_ok = 1'b1;
         inst_rdata   = mem_word(bus_q[0].pa);
      end else if (bus_q.size() == 0 && spur_en && $urandom_range(0, 7) == 0) begin
         inst_data_ok = 1'b1;
      end
      inst_addr_ok = inst_req && (req_q.size() != 0) && (req_wait >= addr_dly_cur);
      #1;
      exp_rdy = !flush && (req_q.size() == 0) && (bus_q.size() < MAX_OUT)
                && ((exp_q.size() + bus_q.size()) < BUF_DEPTH);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("inst_req", 32'(inst_req), 32'(req_q.size() != 0));
      if (inst_req) req_hi++;
      if (req_q.size() != 0) begin
         chk("inst_addr", inst_addr, {req_q[0].pa[31:2], 2'b00});
         chk("inst_uncached", 32'(inst_uncached), 32'(req_q[0].unc));
      end
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (out_valid && out_ready && !flush && exp_q.size() != 0) begin
         chk("out_pc", out_pc, exp_q[0].pc);
         chk("out_inst", out_inst, exp_q[0].inst);
         pop_pc.push_back(out_pc);
         pop_inst.push_back(out_inst);
         void'(exp_q.pop_front());
      end
      // events taking effect at the coming rising edge
      if (inst_data_ok && bus_q.size() != 0) begin
         e = bus_q.pop_front();
         if (e.ep == epoch && !flush) begin
            o.pc = e.pc; o.inst = mem_word(e.pa);
            exp_q.push_back(o);
            chk("buf_not_full_on_live_data", 32'(exp_q.size() <= BUF_DEPTH), 32'd1);
         end
      end
      if (inst_addr_ok) begin
         e = req_q.pop_front();
         e.due = cyc + ((data_dly_fix > 0) ? data_dly_fix : int'($urandom_range(1, 4)));
         bus_q.push_back(e);
         req_wait = 0;
      end else if (req_q.size() != 0) begin
         req_wait++;
      end
      if (in_valid && in_ready) begin
         e = feed_q.pop_front();
         e.ep = epoch;
         req_q.push_back(e);
         req_wait = 0;
         addr_dly_cur = (addr_dly_fix >= 0) ? addr_dly_fix : int'($urandom_range(0, 3));
      end
      if (flush) begin
         exp_q.delete();
         epoch++;
      end
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_paddr = '0; in_uncached = 1'b0;
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0; out_ready = 1'b0;
      #1;
      chk("rst_in_ready_during", 32'(in_ready), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_in_ready_after", 32'(in_ready), 32'd1);
      chk("rst_inst_req", 32'(inst_req), 32'd0);
      chk("rst_inst_addr", inst_addr, 32'd0);
      chk("rst_inst_uncached", 32'(inst_uncached), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_inst", out_inst, 32'd0);
      feed_q.delete(); req_q.delete(); bus_q.delete(); exp_q.delete();
      req_wait = 0;
   endtask

   task automatic run_pops(input int target, input int budget, input string tag);
      for (int i = 0; i < budget && pop_pc.size() < target; i++) step();
      chk(tag, 32'(pop_pc.size()), 32'(target));
   endtask

   initial begin
      int n0;
      bit drained;
      reset = 1'b1;
      do_reset();

      // single cached fetch
      rdy_mode = 1; addr_dly_fix = 1; data_dly_fix = 2;
      n0 = pop_pc.size();
      feed(32'h1C000000, 32'h1C000000, 1'b0);
      run_pops(n0 + 1, 30, "single_count");
      if (pop_pc.size() > n0) begin
         chk("single_pc", pop_pc[n0], 32'h1C000000);
         chk("single_inst", pop_inst[n0], 32'h02800000);
      end

      // back-pressure: two buffered, third held off
      rdy_mode = 0;
      n0 = pop_pc.size();
      feed(32'h0, 32'h1C001000, 1'b0);
      feed(32'h4, 32'h1C001004, 1'b1);
      feed(32'h8, 32'h1C001008, 1'b0);
      repeat (25) step();
      chk("bp_third_held", 32'(feed_q.size()), 32'd1);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      rdy_mode = 1;
      run_pops(n0 + 3, 60, "bp_count");
      if (pop_pc.size() >= n0 + 3) begin
         chk("bp_order0", pop_pc[n0], 32'h0);
         chk("bp_order1", pop_pc[n0 + 1], 32'h4);
         chk("bp_order2", pop_pc[n0 + 2], 32'h8);
      end

      // addr_ok stall for 5 cycles, unaligned paddr
      addr_dly_fix = 5; req_hi = 0;
      n0 = pop_pc.size();
      feed(32'h1C000010, 32'h1C002013, 1'b1);
      run_pops(n0 + 1, 40, "stall_count");
      chk("stall_req_cycles", 32'(req_hi), 32'd6);

      // flush with two outstanding transactions
      addr_dly_fix = 0; data_dly_fix = 10;
      feed(32'h1C000040, 32'h1C000040, 1'b0);
      feed(32'h1C000044, 32'h1C000044, 1'b0);
      for (int i = 0; i < 30 && bus_q.size() < 2; i++) step();
      chk("two_outstanding", 32'(bus_q.size()), 32'd2);
      do_flush = 1; step(); do_flush = 0;
      n0 = pop_pc.size();
      repeat (20) step();
      chk("flush_out_dropped", 32'(pop_pc.size()), 32'(n0));
      data_dly_fix = 2;
      feed(32'h1C000100, 32'h1C000100, 1'b0);
      run_pops(n0 + 1, 30, "post_flush_count");
      if (pop_pc.size() > n0) chk("post_flush_pc", pop_pc[n0], 32'h1C000100);

      // flush while the address phase is stalled
      addr_dly_fix = 4;
      n0 = pop_pc.size();
      feed(32'h1C000200, 32'h1C000200, 1'b0);
      for (int i = 0; i < 10 && req_q.size() == 0; i++) step();
      step();
      do_flush = 1; step(); do_flush = 0;
      repeat (20) step();
      chk("req_flush_dropped", 32'(pop_pc.size()), 32'(n0));
      addr_dly_fix = 1;
      feed(32'h1C000300, 32'h1C000300, 1'b0);
      feed(32'h1C000304, 32'h1C000304, 1'b1);
      run_pops(n0 + 2, 50, "credits_restored");

      // random traffic, then reset in the middle of it
      addr_dly_fix = -1; data_dly_fix = -1; rdy_mode = 2;
      vld_rand = 1; spur_en = 1; flush_rand = 1;
      for (int i = 0; i < 30; i++) feed($urandom(), $urandom(), 1'($urandom_range(0, 1)));
      repeat (40) step();
      do_reset();

      // 100 random-latency fetches checked against the scoreboard
      for (int i = 0; i < 100; i++) feed($urandom(), $urandom(), 1'($urandom_range(0, 1)));
      drained = 0;
      for (int i = 0; i < 3000 && !drained; i++) begin
         step();
         drained = (feed_q.size() == 0) && (req_q.size() == 0) && (bus_q.size() == 0)
                   && (exp_q.size() == 0);
      end
      chk("random_drained", 32'(drained), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
